// File: rtl/fm_synth_pkg.sv
// Shared types and width helpers for the FM voice allocator.
package fm_synth_pkg;

    typedef enum logic [1:0] {IDLE, LOOKUP, APPLY} state_t;

    localparam int NOTE_BITS = 7;
    localparam int VEL_BITS  = 7;

    function automatic int age_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fm_voice_search.sv
// Combinational search over channel state: note match, free slot and oldest voice.
module fm_voice_search #(
    parameter int NUM_CHANNELS = 16,
    parameter int NOTE_BITS    = fm_synth_pkg::NOTE_BITS,
    parameter int AW           = fm_synth_pkg::age_w(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0]                gate,
    input  logic [NUM_CHANNELS-1:0][NOTE_BITS-1:0] note,
    input  logic [NUM_CHANNELS-1:0][AW-1:0]        age,
    input  logic [NOTE_BITS-1:0]                   cmd_note,
    output logic                                   match_hit,
    output logic [AW-1:0]                          match_idx,
    output logic                                   free_hit,
    output logic [AW-1:0]                          free_idx,
    output logic                                   old_hit,
    output logic [AW-1:0]                          old_idx
);

    // Scanning high-to-low lets the lowest index win.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        old_hit   = 1'b0;
        old_idx   = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (gate[i] && note[i] == cmd_note) begin
                match_hit = 1'b1;
                match_idx = AW'(i);
            end
            if (!gate[i]) begin
                free_hit = 1'b1;
                free_idx = AW'(i);
            end
            if (gate[i] && age[i] == AW'(NUM_CHANNELS - 1)) begin
                old_hit = 1'b1;
                old_idx = AW'(i);
            end
        end
    end

endmodule

// File: rtl/fm_voice_alloc.sv
// Polyphonic voice allocator: note commands in, per-channel carrier/velocity/gate out.
module fm_voice_alloc #(
    parameter int NUM_CHANNELS = 16,
    parameter int NUM_BITS     = 32,
    parameter int NOTE_BITS    = fm_synth_pkg::NOTE_BITS,
    parameter int VEL_BITS     = fm_synth_pkg::VEL_BITS
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic                                        cmd_on,
    input  logic [NOTE_BITS-1:0]                        cmd_note,
    input  logic [VEL_BITS-1:0]                         cmd_vel,
    input  logic [NUM_BITS-1:0]                         cmd_inc,
    input  logic                                        mono,
    input  logic                                        all_off,
    output logic [NUM_CHANNELS*NUM_BITS-1:0]            carrier_out,
    output logic [NUM_CHANNELS*NUM_BITS-1:0]            velocity_out,
    output logic [NUM_CHANNELS-1:0]                     gate_out,
    output logic [fm_synth_pkg::cnt_w(NUM_CHANNELS)-1:0] active_count,
    output logic                                        steal_valid,
    output logic [fm_synth_pkg::age_w(NUM_CHANNELS)-1:0] steal_ch
);
    import fm_synth_pkg::*;

    localparam int AW = age_w(NUM_CHANNELS);
    localparam int CW = cnt_w(NUM_CHANNELS);

    typedef struct packed {
        logic                 on;
        logic                 mono;
        logic [NOTE_BITS-1:0] note;
        logic [VEL_BITS-1:0]  vel;
        logic [NUM_BITS-1:0]  inc;
    } cmd_t;

    state_t state, state_nxt;
    cmd_t   cmd;

    logic [NUM_CHANNELS-1:0][NUM_BITS-1:0]  carrier, velocity;
    logic [NUM_CHANNELS-1:0][NOTE_BITS-1:0] note;
    logic [NUM_CHANNELS-1:0]                gate, gate_nxt;
    logic [NUM_CHANNELS-1:0][AW-1:0]        age, age_nxt;
    logic [CW-1:0]                          cnt_nxt;

    logic          s_match_hit, s_free_hit, s_old_hit;
    logic [AW-1:0] s_match_idx, s_free_idx, s_old_idx;
    logic          match_hit, free_hit, old_hit;
    logic [AW-1:0] match_idx, free_idx, old_idx;

    logic          do_on, do_off, steal, tgt_active;
    logic [AW-1:0] tgt, tgt_age;

    assign carrier_out  = carrier;
    assign velocity_out = velocity;
    assign gate_out     = gate;
    assign cmd_ready    = (state == IDLE);

    fm_voice_search #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .NOTE_BITS    (NOTE_BITS),
        .AW           (AW)
    ) u_search (
        .gate      (gate),
        .note      (note),
        .age       (age),
        .cmd_note  (cmd.note),
        .match_hit (s_match_hit),
        .match_idx (s_match_idx),
        .free_hit  (s_free_hit),
        .free_idx  (s_free_idx),
        .old_hit   (s_old_hit),
        .old_idx   (s_old_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (all_off) state_nxt = IDLE;
    end

    // Target selection and age-rank update for the APPLY cycle.
    always_comb begin
        do_on  = 1'b0;
        do_off = 1'b0;
        steal  = 1'b0;
        tgt    = '0;
        if (cmd.mono) begin
            if (cmd.on)                                 do_on  = 1'b1;
            else if (gate[0] && note[0] == cmd.note)    do_off = 1'b1;
        end else if (cmd.on) begin
            do_on = 1'b1;
            if (match_hit)     tgt = match_idx;
            else if (free_hit) tgt = free_idx;
            else if (old_hit) begin
                tgt   = old_idx;
                steal = 1'b1;
            end else do_on = 1'b0;
        end else if (match_hit) begin
            do_off = 1'b1;
            tgt    = match_idx;
        end
        tgt_active = gate[tgt];
        tgt_age    = age[tgt];

        gate_nxt = gate;
        age_nxt  = age;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (do_on && gate[i] && (!tgt_active || age[i] < tgt_age))
                age_nxt[i] = age[i] + AW'(1);
            else if (do_off && gate[i] && age[i] > tgt_age)
                age_nxt[i] = age[i] - AW'(1);
        end
        if (do_on || do_off) begin
            gate_nxt[tgt] = do_on;
            age_nxt[tgt]  = '0;
        end

        cnt_nxt = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) cnt_nxt += CW'(gate_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carrier      <= '0;
            velocity     <= '0;
            note         <= '0;
            gate         <= '0;
            age          <= '0;
            active_count <= '0;
            steal_valid  <= 1'b0;
            steal_ch     <= '0;
            cmd          <= '0;
            match_hit    <= 1'b0;
            match_idx    <= '0;
            free_hit     <= 1'b0;
            free_idx     <= '0;
            old_hit      <= 1'b0;
            old_idx      <= '0;
        end else if (all_off) begin
            gate         <= '0;
            age          <= '0;
            active_count <= '0;
            steal_valid  <= 1'b0;
        end else begin
            steal_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    // Zero velocity folds into note-off here so later stages see one flag.
                    cmd.on   <= cmd_on && (cmd_vel != '0);
                    cmd.mono <= mono;
                    cmd.note <= cmd_note;
                    cmd.vel  <= cmd_vel;
                    cmd.inc  <= cmd_inc;
                end
                LOOKUP: begin
                    match_hit <= s_match_hit;
                    match_idx <= s_match_idx;
                    free_hit  <= s_free_hit;
                    free_idx  <= s_free_idx;
                    old_hit   <= s_old_hit;
                    old_idx   <= s_old_idx;
                end
                APPLY: begin
                    gate         <= gate_nxt;
                    age          <= age_nxt;
                    active_count <= cnt_nxt;
                    if (do_on) begin
                        carrier[tgt]  <= cmd.inc;
                        velocity[tgt] <= NUM_BITS'(cmd.vel);
                        note[tgt]     <= cmd.note;
                    end
                    if (steal) begin
                        steal_valid <= 1'b1;
                        steal_ch    <= tgt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fm_voice_alloc.sv
// Bench for fm_voice_alloc: directed table, corner sequences, randomized run vs a recency-queue model.
module tb_fm_voice_alloc;

    localparam int N = 16;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_on = 1'b0;
    logic [6:0]     cmd_note = '0;
    logic [6:0]     cmd_vel = '0;
    logic [W-1:0]   cmd_inc = '0;
    logic           mono = 1'b0;
    logic           all_off = 1'b0;
    logic [N*W-1:0] carrier_out, velocity_out;
    logic [N-1:0]   gate_out;
    logic [4:0]     active_count;
    logic           steal_valid;
    logic [3:0]     steal_ch;

    always #5 clk = ~clk;

    fm_voice_alloc #(.NUM_CHANNELS(N), .NUM_BITS(W), .NOTE_BITS(7), .VEL_BITS(7)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_on(cmd_on), .cmd_note(cmd_note), .cmd_vel(cmd_vel), .cmd_inc(cmd_inc),
        .mono(mono), .all_off(all_off), .carrier_out(carrier_out),
        .velocity_out(velocity_out), .gate_out(gate_out), .active_count(active_count),
        .steal_valid(steal_valid), .steal_ch(steal_ch)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: channel arrays plus a recency list (front = newest).
    bit         m_gate [N];
    int         m_note [N];
    logic [31:0] m_car [N];
    int         m_vel  [N];
    int         m_q[$];
    bit         m_steal;
    int         m_steal_ch;

    logic [N*W-1:0] obs_car;
    logic [N-1:0]   obs_gate;
    int             obs_cnt;
    bit             obs_steal;
    int             obs_sch;

    task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_gate[i] = 0; m_note[i] = 0; m_car[i] = '0; m_vel[i] = 0;
        end
        m_q.delete();
        m_steal = 0;
    endfunction

    function automatic void m_alloff();
        for (int i = 0; i < N; i++) m_gate[i] = 0;
        m_q.delete();
        m_steal = 0;
    endfunction

    function automatic void m_unlink(input int ch);
        for (int i = 0; i < m_q.size(); i++)
            if (m_q[i] == ch) begin m_q.delete(i); break; end
    endfunction

    function automatic void m_cmd(input bit on, input int n, input int v, input logic [31:0] inc, input bit mo);
        int t;
        t = -1;
        m_steal = 0;
        if (on && v != 0) begin
            if (mo) t = 0;
            else begin
                for (int i = 0; i < N; i++) if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
                for (int i = 0; i < N; i++) if (t < 0 && !m_gate[i]) t = i;
                if (t < 0) begin t = m_q[m_q.size()-1]; m_steal = 1; m_steal_ch = t; end
            end
            m_unlink(t);
            m_q.push_front(t);
            m_gate[t] = 1; m_note[t] = n; m_car[t] = inc; m_vel[t] = v;
        end else begin
            if (mo) begin
                if (m_gate[0] && m_note[0] == n) t = 0;
            end else
                for (int i = 0; i < N; i++) if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
            if (t >= 0) begin m_unlink(t); m_gate[t] = 0; end
        end
    endfunction

    task automatic compare_all(input string tag);
        logic [N*W-1:0] ec, ev;
        logic [N-1:0]   eg;
        for (int i = 0; i < N; i++) begin
            ec[i*W +: W] = m_car[i];
            ev[i*W +: W] = W'(m_vel[i]);
            eg[i]        = m_gate[i];
        end
        chk({tag, ".gate"}, gate_out, eg);
        chk({tag, ".carrier"}, carrier_out, ec);
        chk({tag, ".velocity"}, velocity_out, ev);
        chk({tag, ".count"}, active_count, m_q.size());
        chk({tag, ".steal"}, steal_valid, m_steal);
        if (m_steal) chk({tag, ".steal_ch"}, steal_ch, m_steal_ch);
    endtask

    // One command through the handshake; checks APPLY, T+3 outputs and the pulse end.
    task automatic send(input bit on, input int n, input int v, input logic [31:0] inc, input bit mo, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
        if (!cmd_ready) begin total++; bad++; $display("FAIL %s.ready_timeout: got 0 want 1", tag); end
        cmd_on = on; cmd_note = 7'(n); cmd_vel = 7'(v); cmd_inc = inc; mono = mo; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        m_cmd(on, n, v, inc, mo);
        @(negedge clk);
        chk({tag, ".steal_early"}, steal_valid, 1'b0);
        @(negedge clk);
        obs_car = carrier_out; obs_gate = gate_out; obs_cnt = int'(active_count);
        obs_steal = steal_valid; obs_sch = int'(steal_ch);
        compare_all(tag);
        chk({tag, ".ready"}, cmd_ready, 1'b1);
        @(negedge clk);
        chk({tag, ".steal_pulse"}, steal_valid, 1'b0);
    endtask

    typedef struct {
        bit          on;
        int          note;
        int          vel;
        logic [31:0] inc;
        bit          mo;
        logic [15:0] g;
        int          cnt;
        bit          st;
        int          sch;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int acc[$];
        int cyc, nsent, r;

        tbl[0]  = '{1, 60, 100, 32'h0100_0000, 0, 16'h0001,  1, 0, 0};
        tbl[1]  = '{1, 80,  50, 32'h0200_0000, 0, 16'hffff, 16, 1, 0};
        tbl[2]  = '{1, 64,  90, 32'h0300_0000, 0, 16'hffff, 16, 0, 0};
        tbl[3]  = '{1, 64,  91, 32'h0400_0000, 0, 16'hffff, 16, 0, 0};
        tbl[4]  = '{1, 64,   0, 32'h0500_0000, 0, 16'hffef, 15, 0, 0};
        tbl[5]  = '{0, 90,   0, 32'h0,         0, 16'hffef, 15, 0, 0};
        tbl[6]  = '{1, 81,  10, 32'h0600_0000, 0, 16'hffff, 16, 0, 0};
        tbl[7]  = '{1, 82,  20, 32'h0700_0000, 0, 16'hffff, 16, 1, 1};
        tbl[8]  = '{1, 60, 100, 32'h0800_0000, 1, 16'h0001,  1, 0, 0};
        tbl[9]  = '{1, 62, 100, 32'h0900_0000, 1, 16'h0001,  1, 0, 0};
        tbl[10] = '{0, 60,   0, 32'h0,         1, 16'h0001,  1, 0, 0};
        tbl[11] = '{0, 62,   0, 32'h0,         1, 16'h0000,  0, 0, 0};

        m_reset();
        repeat (3) @(negedge clk);
        chk("rst.carrier", carrier_out, '0);
        chk("rst.velocity", velocity_out, '0);
        chk("rst.gate", gate_out, '0);
        chk("rst.count", active_count, '0);
        chk("rst.steal", steal_valid, 1'b0);
        chk("rst.ready", cmd_ready, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (i == 8) begin
                // all_off while a note-on sits in LOOKUP
                @(negedge clk);
                cmd_on = 1; cmd_note = 7'd70; cmd_vel = 7'd30; cmd_inc = 32'h0a00_0000; mono = 0; cmd_valid = 1'b1;
                @(posedge clk);
                @(negedge clk); cmd_valid = 1'b0; all_off = 1'b1;
                @(negedge clk); all_off = 1'b0;
                m_alloff();
                chk("alloff.gate", gate_out, '0);
                chk("alloff.count", active_count, '0);
                chk("alloff.ready", cmd_ready, 1'b1);
                chk("alloff.steal", steal_valid, 1'b0);
                repeat (2) @(negedge clk);
                compare_all("alloff.dropped");
            end
            send(tbl[i].on, tbl[i].note, tbl[i].vel, tbl[i].inc, tbl[i].mo, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.exp_gate", i), obs_gate, tbl[i].g);
            chk($sformatf("tbl%0d.exp_count", i), obs_cnt, tbl[i].cnt);
            chk($sformatf("tbl%0d.exp_steal", i), obs_steal, tbl[i].st);
            if (tbl[i].st) chk($sformatf("tbl%0d.exp_steal_ch", i), obs_sch, tbl[i].sch);
            if (i == 0) begin
                chk("tbl0.car0", obs_car[31:0], 32'h0100_0000);
                chk("tbl0.vel0", velocity_out[31:0], 32'd100);
                for (int nn = 61; nn <= 75; nn++) send(1, nn, 64, 32'h0010_0000 + nn, 0, "fill");
                chk("fill.count", active_count, 5'd16);
            end
            if (i == 1) chk("tbl1.car0", obs_car[31:0], 32'h0200_0000);
            if (i == 4) chk("tbl4.car4_kept", obs_car[4*W +: W], 32'h0400_0000);
            if (i == 9) chk("tbl9.car0", obs_car[31:0], 32'h0900_0000);
        end

        // cmd_valid held high: accepts exactly 3 cycles apart
        cyc = 0; nsent = 0;
        @(negedge clk);
        cmd_on = 1; cmd_note = 7'd100; cmd_vel = 7'd64; cmd_inc = 32'h0000_1000; mono = 0; cmd_valid = 1'b1;
        while (nsent < 4 && cyc < 40) begin
            if (cmd_ready) begin
                acc.push_back(cyc);
                m_cmd(1, 100 + nsent, 64, 32'h0000_1000 * (nsent + 1), 0);
                nsent++;
                @(negedge clk); cyc++;
                if (nsent < 4) begin
                    cmd_note = 7'(100 + nsent); cmd_inc = 32'h0000_1000 * (nsent + 1);
                end else cmd_valid = 1'b0;
            end else begin
                @(negedge clk); cyc++;
            end
        end
        cmd_valid = 1'b0;
        chk("b2b.accepts", nsent, 4);
        for (int i = 0; i + 1 < acc.size(); i++) chk($sformatf("b2b.gap%0d", i), acc[i+1] - acc[i], 3);
        repeat (2) @(negedge clk);
        compare_all("b2b");

        // rst during APPLY
        @(negedge clk);
        cmd_on = 1; cmd_note = 7'd50; cmd_vel = 7'd40; cmd_inc = 32'h0b00_0000; mono = 0; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        m_reset();
        chk("rst_apply.carrier", carrier_out, '0);
        chk("rst_apply.velocity", velocity_out, '0);
        chk("rst_apply.gate", gate_out, '0);
        chk("rst_apply.count", active_count, '0);
        chk("rst_apply.steal", steal_valid, 1'b0);
        chk("rst_apply.ready", cmd_ready, 1'b1);
        rst = 1'b0;

        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                @(negedge clk); all_off = 1'b1;
                @(negedge clk); all_off = 1'b0;
                m_alloff();
                compare_all("rnd.alloff");
            end else begin
                send(r < 70, 60 + int'($urandom_range(0, 19)),
                     ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 127)),
                     $urandom, $urandom_range(0, 9) == 0, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
